controlador_pulsos: RTL

Sequencer for the button-pulse/LED datapath. It arms a pulse count against a runtime-selected target and counts debounced-free, synchronized rising edges of `botao` within an inactivity window. When the target is reached it lights the LED for a fixed hold time, then re-arms or idles. It sits between the board button and LED and exposes state and count for debug.

---
 rtl/controlador_pulsos_pkg.sv | 16 +
 rtl/detector_borda.sv | 32 +++
 rtl/controlador_pulsos.sv | 138 +++++++++++++
 3 files changed

// File: rtl/controlador_pulsos_pkg.sv
// Shared definitions for the button-pulse/LED sequencer: state encoding and helpers.
package controlador_pulsos_pkg;

    localparam int unsigned LARGURA_ESTADO = 2;

    typedef enum logic [LARGURA_ESTADO-1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        ACESO    = 2'd2
    } estado_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchronizer plus previous-value register; emits a one-cycle rising-edge pulse.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic borda_c
);

    logic sinc1_q, sinc2_q, anterior_q;
    logic sinc1_d, sinc2_d, anterior_d;

    always_comb begin
        sinc1_d    = entrada;
        sinc2_d    = sinc1_q;
        anterior_d = sinc2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sinc1_q    <= 1'b0;
            sinc2_q    <= 1'b0;
            anterior_q <= 1'b0;
        end else begin
            sinc1_q    <= sinc1_d;
            sinc2_q    <= sinc2_d;
            anterior_q <= anterior_d;
        end
    end

    assign borda_c = sinc2_q & ~anterior_q;

endmodule

// File: rtl/controlador_pulsos.sv
// Counts button edges against a latched target, lights the LED for a fixed hold,
// and times out on inactivity. One timer serves both the inactivity window and the hold.
module controlador_pulsos
    import controlador_pulsos_pkg::*;
#(
    parameter int unsigned LARGURA_ALVO   = 3,
    parameter int unsigned TIMEOUT_CICLOS = 1000,
    parameter int unsigned LED_CICLOS     = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      habilitar,
    input  logic [LARGURA_ALVO-1:0]   alvo,
    input  logic                      botao,
    output logic                      led,
    output logic                      concluido,
    output logic                      expirou,
    output logic [LARGURA_ESTADO-1:0] estado_out,
    output logic [LARGURA_ALVO-1:0]   contador_out
);

    localparam int unsigned LARGURA_TIMER = $clog2(max_u(TIMEOUT_CICLOS, LED_CICLOS));

    estado_t                  estado_q, estado_d;
    logic [LARGURA_ALVO-1:0]  contador_q, contador_d;
    logic [LARGURA_ALVO-1:0]  alvo_q, alvo_d;
    logic [LARGURA_TIMER-1:0] timer_q, timer_d;
    logic                     led_q, led_d;
    logic                     concluido_q, concluido_d;
    logic                     expirou_q, expirou_d;
    logic                     borda_c;
    logic [LARGURA_ALVO-1:0]  contador_mais1_c;

    detector_borda u_detector_borda (
        .clk     (clk),
        .reset   (reset),
        .entrada (botao),
        .borda_c (borda_c)
    );

    assign contador_mais1_c = contador_q + LARGURA_ALVO'(1);

    always_comb begin
        estado_d    = estado_q;
        contador_d  = contador_q;
        alvo_d      = alvo_q;
        timer_d     = timer_q;
        led_d       = 1'b0;
        concluido_d = 1'b0;
        expirou_d   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                contador_d = '0;
                timer_d    = '0;
                if (habilitar && (alvo != '0)) begin
                    alvo_d   = alvo;
                    estado_d = CONTANDO;
                end
            end

            // Priority: disable, then edge, then timeout.
            CONTANDO: begin
                if (!habilitar) begin
                    contador_d = '0;
                    timer_d    = '0;
                    estado_d   = OCIOSO;
                end else if (borda_c) begin
                    timer_d = '0;
                    if (contador_mais1_c == alvo_q) begin
                        concluido_d = 1'b1;
                        contador_d  = '0;
                        timer_d     = LARGURA_TIMER'(LED_CICLOS - 1);
                        led_d       = 1'b1;
                        estado_d    = ACESO;
                    end else begin
                        contador_d = contador_mais1_c;
                    end
                end else if (timer_q == LARGURA_TIMER'(TIMEOUT_CICLOS - 1)) begin
                    expirou_d  = 1'b1;
                    contador_d = '0;
                    timer_d    = '0;
                    estado_d   = OCIOSO;
                end else begin
                    timer_d = timer_q + LARGURA_TIMER'(1);
                end
            end

            // Hold counts down; button edges are deliberately not consulted here.
            ACESO: begin
                if (timer_q == '0) begin
                    if (habilitar && (alvo != '0)) begin
                        alvo_d   = alvo;
                        estado_d = CONTANDO;
                    end else begin
                        estado_d = OCIOSO;
                    end
                end else begin
                    led_d   = 1'b1;
                    timer_d = timer_q - LARGURA_TIMER'(1);
                end
            end

            default: begin
                contador_d = '0;
                timer_d    = '0;
                estado_d   = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            contador_q  <= '0;
            alvo_q      <= '0;
            timer_q     <= '0;
            led_q       <= 1'b0;
            concluido_q <= 1'b0;
            expirou_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            contador_q  <= contador_d;
            alvo_q      <= alvo_d;
            timer_q     <= timer_d;
            led_q       <= led_d;
            concluido_q <= concluido_d;
            expirou_q   <= expirou_d;
        end
    end

    assign led          = led_q;
    assign concluido    = concluido_q;
    assign expirou      = expirou_q;
    assign estado_out   = estado_q;
    assign contador_out = contador_q;

endmodule
